// File: rtl/fingerprint_pkg.sv
// Shared types and band layout for the fingerprint front end: FSM states,
// peak record format and the logarithmic band table.
package fingerprint_pkg;

  localparam int unsigned NUM_BINS    = 512;
  localparam int unsigned PEAK_BIN_W  = $clog2(NUM_BINS);
  localparam int unsigned PEAK_MAG_W  = 16;
  localparam int unsigned BAND_COUNT  = 6;
  localparam int unsigned PEAK_BAND_W = $clog2(BAND_COUNT);

  // Exclusive upper bin of each band; the last entry closes the frame.
  localparam int unsigned BAND_END [BAND_COUNT] = '{10, 20, 40, 80, 160, 512};

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, COOL} state_t;

  typedef struct packed {
    logic [PEAK_BAND_W-1:0] band;
    logic [PEAK_BIN_W-1:0]  bin;
    logic [PEAK_MAG_W-1:0]  mag;
  } peak_rec_t;

  function automatic logic [PEAK_BIN_W:0] band_end(input logic [PEAK_BAND_W-1:0] band);
    band_end = (PEAK_BIN_W+1)'(NUM_BINS);
    for (int i = 0; i < int'(BAND_COUNT); i++) begin
      if (band == PEAK_BAND_W'(i)) band_end = (PEAK_BIN_W+1)'(BAND_END[i]);
    end
  endfunction

endpackage

// File: rtl/band_max_tracker.sv
// Running maximum of one band: strict compare so the earliest equal bin wins,
// plus a combinational merge of the in-flight sample for the band-end record.
module band_max_tracker #(
  parameter int unsigned BIN_W = 9,
  parameter int unsigned MAG_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [BIN_W-1:0] start_bin,
  input  logic             sample_valid,
  input  logic [MAG_W-1:0] sample_mag,
  input  logic [BIN_W-1:0] sample_bin,
  output logic [MAG_W-1:0] merged_mag,
  output logic [BIN_W-1:0] merged_bin
);

  logic [MAG_W-1:0] best_mag_q, best_mag_d;
  logic [BIN_W-1:0] best_bin_q, best_bin_d;
  logic             take_new;

  assign take_new   = sample_valid && (sample_mag > best_mag_q);
  assign merged_mag = take_new ? sample_mag : best_mag_q;
  assign merged_bin = take_new ? sample_bin : best_bin_q;

  always_comb begin
    // NOTE: defaults first on every path, so no latch is inferred.
    best_mag_d = best_mag_q;
    best_bin_d = best_bin_q;
    if (clear) begin
      best_mag_d = '0;
      best_bin_d = start_bin;
    end else if (take_new) begin
      best_mag_d = sample_mag;
      best_bin_d = sample_bin;
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_mag_q <= '0;
      best_bin_q <= '0;
    end else begin
      best_mag_q <= best_mag_d;
      best_bin_q <= best_bin_d;
    end
  end

endmodule

// File: rtl/magnitude_peak_picker.sv
// Sweeps the magnitude producer bin by bin after each FFT frame and emits one
// (band, bin, magnitude) peak record per logarithmic band.
module magnitude_peak_picker #(
  parameter int unsigned MAGNITUDES_COUNT = 512,
  parameter int unsigned MAGNITUDE_N      = $clog2(MAGNITUDES_COUNT),
  parameter int unsigned BAND_COUNT       = fingerprint_pkg::BAND_COUNT,
  parameter int unsigned MAG_W            = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          done_fft,
  input  logic                          done_all_processing,
  input  logic [MAG_W-1:0]              magnitude,
  input  logic                          magnitude_ready,
  output logic [MAGNITUDE_N:0]          index,
  output logic                          peak_valid,
  output logic [$clog2(BAND_COUNT)-1:0] peak_band,
  output logic [MAGNITUDE_N-1:0]        peak_bin,
  output logic [MAG_W-1:0]              peak_mag,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic                          busy
);
  import fingerprint_pkg::*;

  localparam int unsigned BW = $clog2(BAND_COUNT);
  localparam logic [MAGNITUDE_N:0] END_IDX  = (MAGNITUDE_N+1)'(MAGNITUDES_COUNT);
  localparam logic [MAGNITUDE_N:0] LAST_BIN = (MAGNITUDE_N+1)'(MAGNITUDES_COUNT - 1);

  state_t               state_q, state_d;
  logic [MAGNITUDE_N:0] index_q, index_d;
  logic [BW-1:0]        band_q, band_d;
  logic                 peak_valid_q, peak_valid_d;
  peak_rec_t            peak_q, peak_d;
  logic                 frame_done_q, frame_done_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic                 busy_q, busy_d;

  logic                   trk_clear;
  logic [MAGNITUDE_N-1:0] trk_start;
  logic                   sample_valid;
  logic [MAG_W-1:0]       merged_mag;
  logic [MAGNITUDE_N-1:0] merged_bin;
  logic [MAGNITUDE_N:0]   band_end_cur;
  logic                   band_last;

  assign sample_valid = (state_q == SWEEP) && magnitude_ready;
  assign band_end_cur = band_end(band_q);
  assign band_last    = (index_q == band_end_cur - 1'b1);

  band_max_tracker #(
    .BIN_W (MAGNITUDE_N),
    .MAG_W (MAG_W)
  ) u_tracker (
    .clk          (clk),
    .reset        (reset),
    .clear        (trk_clear),
    .start_bin    (trk_start),
    .sample_valid (sample_valid),
    .sample_mag   (magnitude),
    .sample_bin   (index_q[MAGNITUDE_N-1:0]),
    .merged_mag   (merged_mag),
    .merged_bin   (merged_bin)
  );

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    band_d        = band_q;
    peak_valid_d  = 1'b0;
    peak_d        = peak_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    trk_clear     = 1'b0;
    trk_start     = '0;
    unique case (state_q)
      IDLE: begin
        index_d = '0;
        if (done_fft && !done_all_processing) begin
          state_d   = SWEEP;
          band_d    = '0;
          trk_clear = 1'b1;
        end
      end
      SWEEP: begin
        if (magnitude_ready) begin
          index_d = index_q + 1'b1;
          if (band_last) begin
            // Record folds in the current bin; tracker restarts at the next band.
            peak_valid_d = 1'b1;
            peak_d       = '{band: band_q, bin: merged_bin, mag: merged_mag};
            trk_clear    = 1'b1;
            trk_start    = band_end_cur[MAGNITUDE_N-1:0];
            band_d       = (band_q == BW'(BAND_COUNT - 1)) ? '0 : band_q + 1'b1;
          end
          if (index_q == LAST_BIN) state_d = DRAIN;
        end
      end
      DRAIN: begin
        index_d = END_IDX;
        if (done_all_processing) begin
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          index_d       = '0;
          state_d       = COOL;
        end
      end
      COOL: begin
        // Wait for the producer to drop its done flag so we never restart twice.
        index_d = '0;
        if (!done_all_processing) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      index_q       <= '0;
      band_q        <= '0;
      peak_valid_q  <= 1'b0;
      peak_q        <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      band_q        <= band_d;
      peak_valid_q  <= peak_valid_d;
      peak_q        <= peak_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      busy_q        <= busy_d;
    end
  end

  assign index       = index_q;
  assign peak_valid  = peak_valid_q;
  assign peak_band   = peak_q.band;
  assign peak_bin    = peak_q.bin;
  assign peak_mag    = peak_q.mag;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_magnitude_peak_picker.sv
// Directed bench for magnitude_peak_picker: a producer model sweeps whole
// frames and the captured peak records are compared with hand-computed tables.
module tb_magnitude_peak_picker;
  import fingerprint_pkg::*;

  localparam int MC = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        done_fft;
  logic        done_all;
  logic [15:0] magnitude;
  logic        magnitude_ready;
  logic [9:0]  index;
  logic        peak_valid;
  logic [2:0]  peak_band;
  logic [8:0]  peak_bin;
  logic [15:0] peak_mag;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  peak_rec_t pk_q[$];
  int exp_bin [6];
  int exp_mag [6];

  magnitude_peak_picker dut (
    .clk                 (clk),
    .reset               (rst),
    .done_fft            (done_fft),
    .done_all_processing (done_all),
    .magnitude           (magnitude),
    .magnitude_ready     (magnitude_ready),
    .index               (index),
    .peak_valid          (peak_valid),
    .peak_band           (peak_band),
    .peak_bin            (peak_bin),
    .peak_mag            (peak_mag),
    .frame_done          (frame_done),
    .frame_count         (frame_count),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mag_of(input int pat, input int bin);
    case (pat)
      0: mag_of = 16'(bin);
      1: mag_of = (bin == 15 || bin == 17) ? 16'd1000 : (bin == 300) ? 16'd5000 : 16'd3;
      default: mag_of = 16'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (peak_valid) pk_q.push_back(peak_rec_t'{band: peak_band, bin: peak_bin, mag: peak_mag});
    if (frame_done) begin
      fd_cnt++;
      check("fd_not_with_peak", {31'd0, peak_valid}, 0);
    end
  end

  task automatic check_peaks(input string tag);
    check({tag, "_count"}, pk_q.size(), 6);
    for (int i = 0; i < 6 && i < pk_q.size(); i++) begin
      check($sformatf("%s_band%0d", tag, i), {29'd0, pk_q[i].band}, i);
      check($sformatf("%s_bin%0d", tag, i), {23'd0, pk_q[i].bin}, exp_bin[i]);
      check($sformatf("%s_mag%0d", tag, i), {16'd0, pk_q[i].mag}, exp_mag[i]);
    end
  endtask

  // One frame through the producer model; optional reset at abort_bin,
  // COOL hold length and a stray strobe while draining.
  task automatic run_frame(input int pat, input int abort_bin, input int hold, input bit spur);
    int idx;
    int n;
    bit got_end;
    pk_q.delete();
    fd_cnt = 0;
    @(posedge clk); #1;
    done_fft = 1'b1;
    done_all = 1'b0;
    n = 0;
    while (!busy && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("sweep_start", {31'd0, busy}, 1);
    got_end = 1'b0;
    for (int k = 0; k < MC + 4 && !got_end; k++) begin
      idx = int'(index);
      if (idx == MC) begin
        got_end = 1'b1;
      end else begin
        magnitude       = mag_of(pat, idx);
        magnitude_ready = 1'b1;
        @(posedge clk); #1;
        magnitude_ready = 1'b0;
        if (idx == abort_bin) begin
          rst = 1'b1;
          #1;
          check("rst_index", {22'd0, index}, 0);
          check("rst_busy", {31'd0, busy}, 0);
          check("rst_peak_valid", {31'd0, peak_valid}, 0);
          check("rst_peak_mag", {16'd0, peak_mag}, 0);
          check("rst_frame_count", {16'd0, frame_count}, 0);
          @(posedge clk); #1;
          rst      = 1'b0;
          done_fft = 1'b0;
          pk_q.delete();
          repeat (10) @(posedge clk);
          #1;
          check("rst_no_peak", pk_q.size(), 0);
          check("rst_no_frame_done", fd_cnt, 0);
          check("rst_idle", {31'd0, busy}, 0);
          return;
        end
        repeat (3) @(posedge clk);
        #1;
      end
    end
    check("sweep_end_seen", {31'd0, got_end}, 1);
    check("drain_index", {22'd0, index}, MC);
    check("frame_done_before_ack", fd_cnt, 0);
    if (spur) begin
      magnitude       = 16'hffff;
      magnitude_ready = 1'b1;
      @(posedge clk); #1;
      magnitude_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("drain_spur_index", {22'd0, index}, MC);
      check("drain_spur_no_peak", pk_q.size(), 6);
    end
    done_all = 1'b1;
    n = 0;
    while (fd_cnt == 0 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (hold) @(posedge clk);
    #1;
    check("cool_index", {22'd0, index}, 0);
    check("cool_busy", {31'd0, busy}, 1);
    check("frame_done_once", fd_cnt, 1);
    done_fft = 1'b0;
    @(posedge clk); #1;
    done_all = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("back_idle_busy", {31'd0, busy}, 0);
    check("back_idle_index", {22'd0, index}, 0);
  endtask

  initial begin
    rst             = 1'b1;
    done_fft        = 1'b0;
    done_all        = 1'b0;
    magnitude       = '0;
    magnitude_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_index", {22'd0, index}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_peak_valid", {31'd0, peak_valid}, 0);
    check("reset_frame_done", {31'd0, frame_done}, 0);
    check("reset_frame_count", {16'd0, frame_count}, 0);
    rst = 1'b0;

    run_frame(0, -1, 2, 1'b0);
    exp_bin = '{9, 19, 39, 79, 159, 511};
    exp_mag = '{9, 19, 39, 79, 159, 511};
    check_peaks("ramp");
    check("ramp_frame_count", {16'd0, frame_count}, 1);

    run_frame(1, -1, 2, 1'b0);
    exp_bin = '{0, 15, 20, 40, 80, 300};
    exp_mag = '{3, 1000, 3, 3, 3, 5000};
    check_peaks("spike");
    check("spike_frame_count", {16'd0, frame_count}, 2);

    run_frame(2, -1, 2, 1'b0);
    exp_bin = '{0, 10, 20, 40, 80, 160};
    exp_mag = '{0, 0, 0, 0, 0, 0};
    check_peaks("zero");
    check("zero_frame_count", {16'd0, frame_count}, 3);

    pk_q.delete();
    magnitude       = 16'd9999;
    magnitude_ready = 1'b1;
    @(posedge clk); #1;
    magnitude_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_spur_index", {22'd0, index}, 0);
    check("idle_spur_no_peak", pk_q.size(), 0);
    check("idle_spur_busy", {31'd0, busy}, 0);

    run_frame(0, 100, 2, 1'b0);
    run_frame(0, -1, 2, 1'b0);
    exp_bin = '{9, 19, 39, 79, 159, 511};
    exp_mag = '{9, 19, 39, 79, 159, 511};
    check_peaks("post_rst");
    check("post_rst_frame_count", {16'd0, frame_count}, 1);

    run_frame(1, -1, 50, 1'b1);
    exp_bin = '{0, 15, 20, 40, 80, 300};
    exp_mag = '{3, 1000, 3, 3, 3, 5000};
    check_peaks("hold");
    check("hold_frame_count", {16'd0, frame_count}, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/magnitude_peak_picker.md
Name: magnitude_peak_picker

Overview:
- Consumer end of the index/magnitude handshake of the FFT magnitude engine.
- After each FFT frame, drives `index` from 0 up to MAGNITUDES_COUNT and captures one magnitude per `magnitude_ready` pulse.
- Tracks the maximum magnitude inside each logarithmic frequency band and emits one peak record (band, bin, magnitude) per band, forming the per-frame constellation points for the fingerprint hasher.

Parameters:
- MAGNITUDES_COUNT, 512, bins per frame; power of two.
- MAGNITUDE_N, $clog2(MAGNITUDES_COUNT), bin address width; not overridden.
- BAND_COUNT, 6, number of bands; must equal the length of the band table in the package.
- MAG_W, 16, magnitude width, unsigned compare.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- done_fft  in  1  FFT frame complete (level, from FFT core)
- done_all_processing  in  1  producer finished sweep (level until done_fft drops)
- magnitude  in  MAG_W  magnitude of bin currently addressed
- magnitude_ready  in  1  one-cycle strobe, magnitude valid
- index  out  MAGNITUDE_N+1  bin request to producer
- peak_valid  out  1  one-cycle strobe, peak record valid
- peak_band  out  $clog2(BAND_COUNT)  band id of record
- peak_bin  out  MAGNITUDE_N  bin of band maximum
- peak_mag  out  MAG_W  band maximum value
- frame_done  out  1  one-cycle strobe after last peak record of a frame
- frame_count  out  16  frames completed, wraps at 65535->0
- busy  out  1  high outside IDLE

Behaviour:
- Reset: async. All outputs 0, index=0, state IDLE, band accumulators cleared. Reset mid-sweep abandons the frame; no peak or frame_done is emitted for it.
- Producer contract:
  - Producer latches `index` when it starts each bin request.
  - It issues a single `magnitude_ready` pulse per bin.
  - It re-checks `index == MAGNITUDES_COUNT` at least 2 cycles after the pulse; equality ends its sweep.
  - Consecutive strobes are at least 4 cycles apart.
- FSM, registered:
  - IDLE: index held at 0. When `done_fft && !done_all_processing`, go to SWEEP; clear band=0, best_mag=0, best_bin=band start (0).
  - SWEEP: on `magnitude_ready`:
    - If `magnitude > best_mag` (strict), set best_mag=magnitude, best_bin=index[MAGNITUDE_N-1:0].
    - index <= index+1 the next cycle. Registered, visible 1 cycle after the strobe, i.e. before the producer's next latch.
    - If index == BAND_END[band]-1, emit a peak record the next cycle. The record includes the current bin's compare via a combinational max of (best, current).
    - Then band++, best_mag=0, best_bin=BAND_END[band_old].
    - If this was bin MAGNITUDES_COUNT-1, index becomes MAGNITUDES_COUNT; go to DRAIN.
  - DRAIN: index held at MAGNITUDES_COUNT. When `done_all_processing`=1, pulse frame_done, frame_count++, go to COOL.
  - COOL: index=0. Return to IDLE when `done_all_processing`=0. This prevents a double start while the producer still reports done.
- Ties: the first bin of equal value wins. A band that is all zeros reports bin = band start, mag = 0.
- Strobe outside SWEEP: ignored; no index change.
- Strobe and band end on the final bin coincide: peak_valid for the last band and the DRAIN transition happen in the same cycle. frame_done follows at least 1 cycle later, so it never coincides with peak_valid.
- `done_fft` deasserting during SWEEP: no effect; the sweep continues until the producer finishes.
- Latency: peak record 1 cycle after the strobe of the band's last bin.

Decomposition:
- Package `fingerprint_pkg`:
  - `BAND_COUNT`.
  - `BAND_END` localparam array {10,20,40,80,160,512}. Exclusive upper bins; the last entry equals MAGNITUDES_COUNT.
  - FSM state typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, COOL}.
  - Peak record struct {band, bin, mag}.
- Sub-module `band_max_tracker`: holds best_mag/best_bin, performs the strict compare, clears to a given start bin. Instantiated once.

Test Plan:
- Ramp frame, magnitude = bin number, producer model with 4-cycle strobe spacing -> 6 peaks (band,bin,mag) = (0,9,9),(1,19,19),(2,39,39),(3,79,79),(4,159,159),(5,511,511); frame_done once; frame_count=1; index ends 512 then returns to 0.
- Spikes: magnitude 1000 at bin 15, 1000 at bin 17, 5000 at bin 300, else 3 -> band1=(1,15,1000), band5=(5,300,5000), others mag 3 at band start.
- All-zero frame -> six records with mag 0 and bins 0,10,20,40,80,160.
- Async reset asserted after bin 100 strobe -> all outputs 0 immediately, no frame_done; next frame produces a full 6-record set and frame_count=1.
- done_all_processing held high 50 cycles after DRAIN, done_fft held high -> exactly one frame_done, no second sweep; index stays 0 in COOL.
- Spurious magnitude_ready in IDLE and DRAIN -> index unchanged, no peak_valid.
